// File: rtl/alien_bomb_pkg.sv
// alien_bomb_pkg: shared invader geometry, bomb timing constants and FSM state type
package alien_bomb_pkg;
  localparam int ALIEN_W = 30;
  localparam int ALIEN_WS = 10;
  localparam int ALIEN_H = 20;
  localparam int ALIEN_HS = 10;
  localparam int NUM_COLS = 10;
  localparam int NUM_ROWS = 5;
  localparam int PLAYER_W = 30;
  localparam int PLAYER_H = 20;
  localparam int BOMB_STEP = 4;
  localparam int FIRE_DELAY = 40;
  localparam int SCREEN_H = 480;
  localparam int PARK_ROW = 500;
  localparam int PARK_COL = 350;
  localparam logic [1:0] START_LIVES = 2'd3;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  typedef enum logic [1:0] {IDLE, SELECT, FALL, DEAD} state_e;
  function automatic logic in_span(input logic [10:0] lo, input logic [10:0] v, input int w);
    return v >= lo && v < lo + 11'(w);
  endfunction
endpackage

// File: rtl/alien_bomb_if.sv
// alien_bomb_if: tick, alien grid, player position and bomb/lives status bundle
interface alien_bomb_if;
  logic        tick;
  logic [8:0]  aliens_row;
  logic [9:0]  aliens_col;
  logic [49:0] aliens_grid;
  logic [8:0]  player_row;
  logic [9:0]  player_col;
  logic [8:0]  bomb_row;
  logic [9:0]  bomb_col;
  logic        bomb_onscreen;
  logic        player_hit;
  logic [1:0]  lives;
  logic        player_defeated;
  modport slave(input tick, aliens_row, aliens_col, aliens_grid, player_row, player_col,
                output bomb_row, bomb_col, bomb_onscreen, player_hit, lives, player_defeated);
  modport master(output tick, aliens_row, aliens_col, aliens_grid, player_row, player_col,
                 input bomb_row, bomb_col, bomb_onscreen, player_hit, lives, player_defeated);
endinterface

// File: rtl/alien_bomb_lfsr8.sv
// lfsr8: free-running 8-bit maximal LFSR (x^8+x^6+x^5+x^4+1) used to pick the firing column
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       Clk,
  input  logic       Reset_n,
  output logic [7:0] q
);
  logic [7:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  always_ff @(posedge Clk) lfsr_q <= !Reset_n ? SEED : lfsr_d;
  assign q = lfsr_q;
endmodule

// File: rtl/alien_bomb.sv
// alien_bomb: picks a live alien column, drops a bomb from its lowest alien, tracks player hits and lives
module alien_bomb
  import alien_bomb_pkg::*;
(
  input logic        Clk,
  input logic        Reset_n,
  alien_bomb_if.slave bus
);
  logic [7:0] lfsr;
  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (.Clk(Clk), .Reset_n(Reset_n), .q(lfsr));
  state_e state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [3:0] col_q, col_d, scans_q, scans_d;
  logic [2:0] row_q, row_d;
  logic [8:0] brow_q, brow_d;
  logic [9:0] bcol_q, bcol_d;
  logic [1:0] lives_q, lives_d;
  logic hit_q, hit_d, on_q, on_d, dead_q, dead_d;
  logic [10:0] spawn_row, spawn_col, step_row;
  logic live, collide;
  always_comb begin
    live = bus.aliens_grid[6'(row_q) * 6'(NUM_COLS) + 6'(col_q)];
    spawn_col = 11'(bus.aliens_col) + 11'(col_q) * 11'(ALIEN_W + ALIEN_WS) + 11'(ALIEN_W / 2);
    spawn_row = 11'(bus.aliens_row) + 11'(row_q) * 11'(ALIEN_H + ALIEN_HS) + 11'(ALIEN_H);
    step_row = 11'(brow_q) + 11'(BOMB_STEP);
    collide = in_span(11'(bus.player_col), 11'(bcol_q), PLAYER_W) &&
              in_span(11'(bus.player_row), 11'(brow_q), PLAYER_H);
    state_d = state_q;
    cnt_d = cnt_q;
    col_d = col_q;
    row_d = row_q;
    scans_d = scans_q;
    brow_d = brow_q;
    bcol_d = bcol_q;
    lives_d = lives_q;
    dead_d = dead_q;
    hit_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cnt_q == 6'd0) begin
          state_d = SELECT;
          col_d = 4'(lfsr % 8'(NUM_COLS));
          row_d = 3'(NUM_ROWS - 1);
          scans_d = 4'd0;
        end else if (bus.tick) cnt_d = cnt_q - 6'd1;
      end
      SELECT: begin
        if (live) begin
          state_d = spawn_row >= 11'(SCREEN_H) ? IDLE : FALL;
          cnt_d = 6'(FIRE_DELAY);
          brow_d = spawn_row >= 11'(SCREEN_H) ? brow_q : 9'(spawn_row);
          bcol_d = spawn_row >= 11'(SCREEN_H) ? bcol_q : 10'(spawn_col);
        end else if (row_q == 3'd0) begin
          row_d = 3'(NUM_ROWS - 1);
          col_d = col_q == 4'(NUM_COLS - 1) ? 4'd0 : col_q + 4'd1;
          scans_d = scans_q + 4'd1;
          state_d = scans_d == 4'(NUM_COLS) ? IDLE : SELECT;
          cnt_d = 6'(FIRE_DELAY);
        end else row_d = row_q - 3'd1;
      end
      FALL: begin
        // a same-cycle hit beats the tick move
        if (collide) begin
          hit_d = 1'b1;
          lives_d = lives_q == 2'd0 ? 2'd0 : lives_q - 2'd1;
          dead_d = lives_q <= 2'd1;
          state_d = lives_q <= 2'd1 ? DEAD : IDLE;
          brow_d = 9'(PARK_ROW);
          cnt_d = 6'(FIRE_DELAY);
        end else if (bus.tick) begin
          state_d = step_row >= 11'(SCREEN_H) ? IDLE : FALL;
          brow_d = step_row >= 11'(SCREEN_H) ? 9'(PARK_ROW) : 9'(step_row);
          cnt_d = 6'(FIRE_DELAY);
        end
      end
      DEAD: brow_d = 9'(PARK_ROW);
      default: state_d = IDLE;
    endcase
    on_d = state_d == FALL;
  end
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q <= 6'(FIRE_DELAY);
      col_q <= 4'd0;
      row_q <= 3'd0;
      scans_q <= 4'd0;
      brow_q <= 9'(PARK_ROW);
      bcol_q <= 10'(PARK_COL);
      lives_q <= START_LIVES;
      dead_q <= 1'b0;
      hit_q <= 1'b0;
      on_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      col_q <= col_d;
      row_q <= row_d;
      scans_q <= scans_d;
      brow_q <= brow_d;
      bcol_q <= bcol_d;
      lives_q <= lives_d;
      dead_q <= dead_d;
      hit_q <= hit_d;
      on_q <= on_d;
    end
  end
  assign bus.bomb_row = brow_q;
  assign bus.bomb_col = bcol_q;
  assign bus.bomb_onscreen = on_q;
  assign bus.player_hit = hit_q;
  assign bus.lives = lives_q;
  assign bus.player_defeated = dead_q;
endmodule

// File: tb/tb_alien_bomb.sv
// tb_alien_bomb: scoreboard bench; expected spawns and post-hit lives are queued and checked as the DUT reports them
module tb_alien_bomb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick_en = 1'b0;
  always #5 clk = ~clk;
  alien_bomb_if bus();
  alien_bomb dut (.Clk(clk), .Reset_n(rst_n), .bus(bus));
  typedef struct {int row; int col;} spawn_t;
  spawn_t spawn_q[$];
  spawn_t s_mon;
  int lives_q[$];
  int n_cmp = 0, n_bad = 0, spawns = 0, hits = 0, last_row = 0, doubles = 0, bad_steps = 0, tc = 0;
  logic prev_on = 1'b0, prev_hit = 1'b0;
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_row"}, int'(bus.bomb_row), 500);
    check({tag, "_col"}, int'(bus.bomb_col), 350);
    check({tag, "_lives"}, int'(bus.lives), 3);
    check({tag, "_onscreen"}, int'(bus.bomb_onscreen), 0);
    check({tag, "_defeated"}, int'(bus.player_defeated), 0);
    check({tag, "_hit"}, int'(bus.player_hit), 0);
  endtask
  task automatic wait_on(input int maxc, input string tag);
    int n = 0;
    while (!bus.bomb_onscreen && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check(tag, int'(bus.bomb_onscreen), 1);
  endtask
  task automatic wait_off(input int maxc, input string tag);
    int n = 0;
    while (bus.bomb_onscreen && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check(tag, int'(bus.bomb_onscreen), 0);
  endtask
  task automatic wait_hits(input int target, input int maxc, input string tag);
    int n = 0;
    while (hits < target && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check(tag, hits, target);
  endtask
  task automatic push_spawn(input int r, input int c);
    spawn_t s;
    s.row = r;
    s.col = c;
    spawn_q.push_back(s);
  endtask
  initial forever begin
    @(negedge clk);
    bus.tick = tick_en && (tc % 4 == 3);
    tc++;
  end
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_on = 1'b0;
      prev_hit = 1'b0;
    end else begin
      if (bus.bomb_onscreen && !prev_on) begin
        spawns++;
        if (spawn_q.size() == 0) check("spawn_expected", int'(bus.bomb_onscreen), 0);
        else begin
          s_mon = spawn_q.pop_front();
          check("spawn_row", int'(bus.bomb_row), s_mon.row);
          check("spawn_col", int'(bus.bomb_col), s_mon.col);
        end
      end
      if (bus.bomb_onscreen && prev_on && int'(bus.bomb_row) != last_row && int'(bus.bomb_row) != last_row + 4)
        bad_steps++;
      if (bus.bomb_onscreen) last_row = int'(bus.bomb_row);
      if (bus.player_hit) begin
        hits++;
        if (prev_hit) doubles++;
        if (lives_q.size() == 0) check("hit_expected", int'(bus.player_hit), 0);
        else check("hit_lives", int'(bus.lives), lives_q.pop_front());
        check("hit_row", int'(bus.bomb_row), 500);
        check("hit_onscreen", int'(bus.bomb_onscreen), 0);
      end
      prev_on = bus.bomb_onscreen;
      prev_hit = bus.player_hit;
    end
  end
  initial begin
    bus.tick = 1'b0;
    bus.aliens_row = 9'd100;
    bus.aliens_col = 10'd50;
    bus.aliens_grid = '0;
    bus.player_row = 9'd0;
    bus.player_col = 10'd0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    bus.aliens_grid = 50'd1 << 42;
    push_spawn(240, 145);
    tick_en = 1'b1;
    wait_on(400, "spawn1_seen");
    wait_off(300, "park1_seen");
    check("park1_row", int'(bus.bomb_row), 500);
    check("park1_last_row", last_row, 476);
    check("park1_lives", int'(bus.lives), 3);
    bus.aliens_grid = '0;
    repeat (240) @(negedge clk);
    check("empty_grid_spawns", spawns, 1);
    check("empty_grid_onscreen", int'(bus.bomb_onscreen), 0);
    bus.aliens_row = 9'd60;
    bus.aliens_col = 10'd200;
    push_spawn(80, 495);
    bus.aliens_grid = 50'd1 << 7;
    wait_on(400, "spawn2_seen");
    wait_off(500, "park2_seen");
    check("park2_row", int'(bus.bomb_row), 500);
    check("park2_last_row", last_row, 476);
    bus.player_row = 9'd300;
    bus.player_col = 10'd130;
    bus.aliens_row = 9'd400;
    bus.aliens_col = 10'd50;
    bus.aliens_grid = 50'd1 << 42;
    repeat (400) @(negedge clk);
    check("offscreen_spawn_discarded", spawns, 2);
    push_spawn(240, 145);
    lives_q.push_back(2);
    bus.aliens_row = 9'd100;
    for (int i = 0; i < 3; i++) begin
      wait_on(400, "hit_spawn_seen");
      wait_hits(i + 1, 200, "hit_count");
      if (i < 2) begin
        push_spawn(240, 145);
        lives_q.push_back(1 - i);
      end
    end
    check("dead_lives", int'(bus.lives), 0);
    check("dead_defeated", int'(bus.player_defeated), 1);
    repeat (4000) @(negedge clk);
    check("dead_spawns", spawns, 5);
    check("dead_onscreen", int'(bus.bomb_onscreen), 0);
    check("dead_row", int'(bus.bomb_row), 500);
    check("dead_defeated_sticky", int'(bus.player_defeated), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    push_spawn(240, 145);
    wait_on(400, "refire_seen");
    repeat (20) @(negedge clk);
    check("midfall_onscreen", int'(bus.bomb_onscreen), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("midfall_reset");
    rst_n = 1'b1;
    check("hit_pulse_doubles", doubles, 0);
    check("fall_step_errors", bad_steps, 0);
    check("spawn_queue_left", spawn_q.size(), 0);
    check("lives_queue_left", lives_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
